// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch (I) and data (D) ports.
// D has priority; a streak guard forces an I grant after MAX_D_STREAK back-to-back D grants.
module mem_arbiter #(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [STREAK_W-1:0] streak, streak_n;
  logic                owner_d, owner_d_n;
  logic                mem_en_n, mem_we_n;
  logic [31:0]         mem_addr_n, mem_wdata_n;
  logic [31:0]         i_rdata_n, d_rdata_n;
  logic                i_ready_n, d_ready_n;
  logic                grant_i;

  // I wins when D is idle or D has used up its streak allowance
  assign grant_i = i_req && (!d_req || (streak == STREAK_W'(MAX_D_STREAK)));

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    streak_n    = streak;
    owner_d_n   = owner_d;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    i_ready_n   = 1'b0;
    d_ready_n   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_n  = ACCESS;
          cnt_n    = CNT_W'(LATENCY - 1);
          mem_en_n = 1'b1;
          if (grant_i) begin
            owner_d_n   = 1'b0;
            mem_we_n    = 1'b0;
            mem_addr_n  = i_addr;
            mem_wdata_n = 32'h0;
            streak_n    = '0;
          end else begin
            owner_d_n   = 1'b1;
            mem_we_n    = d_we;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
            if (!i_req) begin
              streak_n = '0;
            end else if (streak < STREAK_W'(MAX_D_STREAK)) begin
              streak_n = streak + STREAK_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_n  = DONE;
          mem_en_n = 1'b0;
          mem_we_n = 1'b0;
          if (owner_d) begin
            d_ready_n = 1'b1;
            if (!mem_we) d_rdata_n = mem_rdata;
          end else begin
            i_ready_n = 1'b1;
            i_rdata_n = mem_rdata;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      owner_d   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      i_rdata   <= 32'h0;
      d_rdata   <= 32'h0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      streak    <= streak_n;
      owner_d   <= owner_d_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      i_ready   <= i_ready_n;
      d_ready   <= d_ready_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LATENCY=2 instance plus a LATENCY=1 instance, scoreboarded completions.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, i_ready, d_req, d_we, d_ready, mem_en, mem_we;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        b_rst, b_i_req, b_i_ready, b_d_req, b_d_we, b_d_ready, b_mem_en, b_mem_we;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t q1[$];

  mem_arbiter #(.LATENCY(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(LAT1), .MAX_D_STREAK(MAXS)) dut1 (
    .clk(clk), .rst(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h0062_0233;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: data is only valid in the last held cycle, garbage before that
  int en_cnt = 0;
  int en_cnt1 = 0;
  always @(posedge clk) en_cnt  <= mem_en   ? en_cnt + 1  : 0;
  always @(posedge clk) en_cnt1 <= b_mem_en ? en_cnt1 + 1 : 0;
  assign mem_rdata   = (mem_en   && en_cnt  == LAT - 1)  ? mem_val(mem_addr)   : 32'hBAD0_BAD0;
  assign b_mem_rdata = (b_mem_en && en_cnt1 == LAT1 - 1) ? mem_val(b_mem_addr) : 32'hBAD0_BAD0;

  // Scoreboard monitor for the LATENCY=2 instance
  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] obs;
    if (!rst) begin
      if (i_ready && d_ready) begin
        tests++; fails++;
        $display("FAIL both_ready i_ready=%b d_ready=%b required one-hot", i_ready, d_ready);
      end else if (i_ready || d_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready i=%b d=%b with nothing expected", i_ready, d_ready);
        end else begin
          e = q.pop_front();
          obs = d_ready ? d_rdata : i_rdata;
          if (d_ready !== e.is_d || obs !== e.data) begin
            fails++;
            $display("FAIL sb_ready got is_d=%b data=%h required is_d=%b data=%h",
                     d_ready, obs, e.is_d, e.data);
          end
        end
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    logic [31:0] obs;
    if (!b_rst && (b_i_ready || b_d_ready)) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL lat1_unexpected_ready i=%b d=%b", b_i_ready, b_d_ready);
      end else begin
        e = q1.pop_front();
        obs = b_d_ready ? b_d_rdata : b_i_rdata;
        if (b_d_ready !== e.is_d || b_i_ready === b_d_ready || obs !== e.data) begin
          fails++;
          $display("FAIL lat1_sb_ready got is_d=%b data=%h required is_d=%b data=%h",
                   b_d_ready, obs, e.is_d, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    b_i_req = 0; b_d_req = 0; b_d_we = 0; b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({i_ready, d_ready, mem_en, mem_we} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
        || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs rdy=%b%b en=%b we=%b addr=%h wd=%h ir=%h dr=%h required all 0",
               i_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    tests++;
    if ({b_i_ready, b_d_ready, b_mem_en, b_mem_we} !== 4'b0 || b_mem_addr !== 32'h0
        || b_i_rdata !== 32'h0 || b_d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs_lat1 en=%b addr=%h required 0", b_mem_en, b_mem_addr);
    end
    rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_fetch();
    q.push_back('{1'b0, 32'h0062_0233});
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h10;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (mem_en !== (c <= LAT) || mem_we !== 1'b0 || (c <= LAT && mem_addr !== 32'h10)
          || i_ready !== (c == LAT + 1) || d_ready !== 1'b0) begin
        fails++;
        $display("FAIL fetch_c%0d en=%b we=%b addr=%h i_ready=%b required en=%b addr=10 i_ready=%b",
                 c, mem_en, mem_we, mem_addr, i_ready, (c <= LAT), (c == LAT + 1));
      end
      if (c == LAT + 1) i_req = 1'b0;
    end
  endtask

  task automatic test_write();
    q.push_back('{1'b1, 32'h0});
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (mem_en !== (c <= LAT) || mem_we !== (c <= LAT)
          || (c <= LAT && (mem_addr !== 32'h64 || mem_wdata !== 32'hDEAD_BEEF))
          || d_ready !== (c == LAT + 1)) begin
        fails++;
        $display("FAIL write_c%0d en=%b we=%b addr=%h wd=%h d_ready=%b required we=%b d_ready=%b",
                 c, mem_en, mem_we, mem_addr, mem_wdata, d_ready, (c <= LAT), (c == LAT + 1));
      end
      if (c == LAT + 1) begin d_req = 1'b0; d_we = 1'b0; end
    end
  endtask

  task automatic test_priority();
    q.push_back('{1'b1, mem_val(32'h40)});
    q.push_back('{1'b0, mem_val(32'h20)});
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (d_ready !== (c == LAT + 1) || i_ready !== (c == 2 * LAT + 3)
          || (c == 1 && mem_addr !== 32'h40) || (c == LAT + 3 && mem_addr !== 32'h20)
          || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL priority_c%0d d_ready=%b i_ready=%b addr=%h required d=%b i=%b",
                 c, d_ready, i_ready, mem_addr, (c == LAT + 1), (c == 2 * LAT + 3));
      end
      if (c == LAT + 1) d_req = 1'b0;
      if (c == 2 * LAT + 3) i_req = 1'b0;
    end
  endtask

  task automatic test_streak();
    int n;
    logic seq [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    foreach (seq[k]) q.push_back('{seq[k], seq[k] ? mem_val(32'h80) : mem_val(32'h90)});
    n = 0;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h90;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int c = 1; c <= 11 * (LAT + 2) + 20 && n < 11; c++) begin
      @(posedge clk); @(negedge clk);
      if (i_ready || d_ready) begin
        n++;
        if (n == 11) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    tests++;
    if (n != 11) begin
      fails++;
      i_req = 1'b0; d_req = 1'b0;
      $display("FAIL streak_timeout completions=%0d required 11", n);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int c = 1; c <= 3 + LAT + 2; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 3) begin
        tests++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || d_ready !== 1'b0 || i_ready !== 1'b0
            || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
          fails++;
          $display("FAIL reset_mid en=%b we=%b d_ready=%b ir=%h dr=%h required all 0",
                   mem_en, mem_we, d_ready, i_rdata, d_rdata);
        end
      end else if (c > 3) begin
        tests++;
        if (mem_en !== (c >= 4 && c <= 3 + LAT) || i_ready !== (c == 3 + LAT + 1)
            || d_ready !== 1'b0) begin
          fails++;
          $display("FAIL reset_mid_fetch_c%0d en=%b i_ready=%b required en=%b i_ready=%b",
                   c, mem_en, i_ready, (c >= 4 && c <= 3 + LAT), (c == 3 + LAT + 1));
        end
      end
      if (c == 2) begin rst = 1'b1; d_req = 1'b0; end
      if (c == 3) begin
        rst = 1'b0;
        q.push_back('{1'b0, mem_val(32'h30)});
        i_req = 1'b1; i_addr = 32'h30;
      end
      if (c == 3 + LAT + 1) i_req = 1'b0;
    end
  endtask

  task automatic test_latency1();
    q1.push_back('{1'b1, mem_val(32'h50)});
    @(posedge clk); #1;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h50;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (b_mem_en !== (c == 1) || b_d_ready !== (c == 2)) begin
        fails++;
        $display("FAIL lat1_single_c%0d en=%b d_ready=%b required en=%b d_ready=%b",
                 c, b_mem_en, b_d_ready, (c == 1), (c == 2));
      end
      if (c == 2) b_d_req = 1'b0;
    end
    q1.push_back('{1'b1, mem_val(32'h100)});
    q1.push_back('{1'b1, mem_val(32'h104)});
    q1.push_back('{1'b1, mem_val(32'h108)});
    @(posedge clk); #1;
    b_d_req = 1'b1; b_d_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if (b_mem_en !== (c % 3 == 1) || b_d_ready !== (c % 3 == 2)) begin
        fails++;
        $display("FAIL lat1_b2b_c%0d en=%b d_ready=%b required en=%b d_ready=%b",
                 c, b_mem_en, b_d_ready, (c % 3 == 1), (c % 3 == 2));
      end
      if (c == 2) b_d_addr = 32'h104;
      if (c == 5) b_d_addr = 32'h108;
      if (c == 8) b_d_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_priority();
    test_streak();
    test_reset_mid();
    test_latency1();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL sb_drain pending=%0d/%0d required 0/0", q.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's fetch port (I) and memory-stage data port (D).
- Sits between the pipelined core and the unified memory, replacing the separate imem/dmem pair.
- Sequences multi-cycle accesses, gives D priority with a starvation guard for I, and returns per-port ready pulses that the core uses as stall releases.

Parameters:
- LATENCY, 2: cycles mem_en/address must be held per access (>=1); mem_rdata valid in the last held cycle.
- MAX_D_STREAK, 4: consecutive D grants allowed while i_req is pending before I is forced (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched instruction, valid when i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1=write, 0=read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid when d_ready=1 after a read
- d_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0, streak counter 0; i_rdata/d_rdata cleared to 0.
- FSM states are IDLE, ACCESS and DONE. All outputs are registered.
- IDLE:
  - No request: stay IDLE.
  - Otherwise pick a winner, latch owner/addr/we/wdata, load cnt=LATENCY-1, then go to ACCESS.
- Priority:
  - Grant D if d_req=1, unless i_req=1 and streak==MAX_D_STREAK, in which case grant I.
  - Grant I if only i_req=1.
- Streak counter:
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, or on a D grant while i_req=0.
  - Saturates at MAX_D_STREAK.
- ACCESS:
  - mem_en=1 and mem_addr/mem_we/mem_wdata come from the latched values.
  - mem_we=1 only when D owns the access with we=1; mem_wdata=0 for I.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata into the owner's rdata register (reads only; d_rdata holds its prior value on writes), drop mem_en/mem_we next cycle, go to DONE.
- DONE:
  - Owner's ready=1 for exactly this cycle. No arbitration occurs in DONE.
  - Next state is IDLE. The requester drops or changes its request in this cycle.
- Latency: request-to-ready = LATENCY+1 cycles. A sustained stream gives one completion per LATENCY+2 cycles.
- i_ready and d_ready are never both 1. An input request is ignored unless the FSM is in IDLE.
- Simultaneous i_req and d_req in IDLE: D wins unless the streak guard applies. The loser waits in IDLE for the next arbitration.
- Requests changing while not owner: no effect. Owner inputs changing mid-access: ignored, because latched values are used.
- Reset mid-operation:
  - Next cycle is IDLE with mem_en=mem_we=0, no ready pulse, streak=0.
  - An in-flight write may or may not have committed; the core is also reset.
- Address/data are passed through unmodified; no alignment checking.

Test Plan:
- LATENCY=2, i_req=1 with i_addr=0x0000_0010 at cycle 0, mem_rdata=0x0062_0233 at cycle 2 -> mem_en=1 in cycles 1-2, mem_addr=0x10, i_ready=1 at cycle 3 only, i_rdata=0x0062_0233.
- d_req=1, d_we=1, d_addr=0x64, d_wdata=0xDEAD_BEEF -> mem_we=1 in cycles 1-2, mem_wdata=0xDEADBEEF, d_ready pulse at cycle 3, d_rdata unchanged (0 after reset).
- i_req and d_req both 1 at cycle 0 -> D granted first (d_ready at cycle 3), I granted at cycle 4 IDLE, i_ready at cycle 7.
- MAX_D_STREAK=4, d_req and i_req held continuously -> grant order D,D,D,D,I,D…; after the I completion the streak clears.
- rst pulsed at cycle 2 of a D read -> cycle 3: mem_en=0, d_ready=0, state IDLE; a fresh i_req completes normally with i_ready at LATENCY+1.
- LATENCY=1 corner: single read -> mem_en for 1 cycle, ready at cycle 2; back-to-back D reads complete every 3 cycles.
